// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared vending definitions. Holds the dispense sequencer
//                state encoding, the change width and maximum valid change,
//                and the coin codes used by the vending core.
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Change is counted in Rs5 units.
    localparam int                    c_change_w   = 3;
    localparam logic [c_change_w-1:0] c_max_change = 3'd5;
    localparam logic [c_change_w-1:0] c_one_coin   = 3'd1;

    // Coin codes reported by the acceptor to the vending core.
    localparam logic [1:0] c_coin_none = 2'd0;
    localparam logic [1:0] c_coin_rs5  = 2'd1;
    localparam logic [1:0] c_coin_rs10 = 2'd2;
    localparam logic [1:0] c_coin_bad  = 2'd3;

    // Dispense sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MOTOR   = 3'd1,
        ST_PAY_REQ = 3'd2,
        ST_PAY_REL = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // Change amounts above c_max_change cannot be paid out.
    function automatic logic change_valid(input logic [c_change_w-1:0] amount);
        return (amount <= c_max_change);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispense_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dispense_timer
//  Description : Loadable down-counter with zero flag. Load has priority
//                over counting; the count holds at zero.
//  Ports       : clock, reset (async, active-low)
//                i_load / i_load_value : load a new count
//                i_enable              : decrement by one while nonzero
//                o_zero                : count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module dispense_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_dispense_sequencer
//  Description : Runs the product motor for MOTOR_CYCLES after a vend, then
//                pays owed change one Rs5 coin at a time over a four-phase
//                req/ack handshake with the hopper. The coin slot is held
//                inhibited while a sequence (or fault) is active.
//  Ports       : clock, reset (async, active-low)
//                vend, change[2:0]      : vend pulse and change owed (Rs5)
//                hopper_ack             : hopper coin acknowledge
//                clear_fault            : clears fault and overrun
//                coin_inhibit, motor_on, hopper_req, done, fault, overrun
//  Macro       : DISPENSE_TIMEOUT_EN enables the hopper ack watchdog
//                (ACK_TIMEOUT cycles per handshake edge).
//  Revision    : 1.0  initial release
// ============================================================================
module vend_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vend,
    input  logic [c_change_w-1:0] change,
    input  logic                  hopper_ack,
    input  logic                  clear_fault,
    output logic                  coin_inhibit,
    output logic                  motor_on,
    output logic                  hopper_req,
    output logic                  done,
    output logic                  fault,
    output logic                  overrun
);

    if (MOTOR_CYCLES < 1) begin : g_bad_motor_cycles
        $error("MOTOR_CYCLES must be at least 1");
    end
    if (ACK_TIMEOUT < 2) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be at least 2");
    end

    // The motor timer is loaded with MOTOR_CYCLES-1 so its zero flag marks
    // the last motor cycle.
    localparam int                   c_motor_w    = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
    localparam logic [c_motor_w-1:0] c_motor_load = c_motor_w'(MOTOR_CYCLES - 1);

    state_t                r_state;
    logic [c_change_w-1:0] r_remaining;
    logic                  r_coin_inhibit;
    logic                  r_motor_on;
    logic                  r_hopper_req;
    logic                  r_done;
    logic                  r_fault;
    logic                  r_overrun;

    logic w_motor_load;
    logic w_motor_en;
    logic w_motor_zero;
    logic w_timeout;

    assign w_motor_load = (r_state == ST_IDLE) && vend && change_valid(change);
    assign w_motor_en   = (r_state == ST_MOTOR);

    dispense_timer #(
        .WIDTH (c_motor_w)
    ) u_motor_timer (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_motor_load),
        .i_load_value (c_motor_load),
        .i_enable     (w_motor_en),
        .o_zero       (w_motor_zero)
    );

`ifdef DISPENSE_TIMEOUT_EN
    // Watchdog restarts on every entry to PAY_REQ/PAY_REL. Loading with
    // ACK_TIMEOUT-1 lets the awaited ack edge be accepted on the last
    // allowed cycle before the timeout is declared.
    localparam int                c_wd_w    = $clog2(ACK_TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_load = c_wd_w'(ACK_TIMEOUT - 1);

    logic w_wd_load;
    logic w_wd_en;
    logic w_wd_zero;

    always_comb begin
        w_wd_load = 1'b0;
        case (r_state)
            ST_MOTOR:   w_wd_load = w_motor_zero && (r_remaining != '0);
            ST_PAY_REQ: w_wd_load = hopper_ack;
            ST_PAY_REL: w_wd_load = !hopper_ack && (r_remaining != '0);
            default:    w_wd_load = 1'b0;
        endcase
    end

    assign w_wd_en   = (r_state == ST_PAY_REQ) || (r_state == ST_PAY_REL);
    assign w_timeout = w_wd_zero;

    dispense_timer #(
        .WIDTH (c_wd_w)
    ) u_watchdog (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_wd_load),
        .i_load_value (c_wd_load),
        .i_enable     (w_wd_en),
        .o_zero       (w_wd_zero)
    );
`else
    // Without the watchdog the hopper is waited on indefinitely.
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_remaining    <= '0;
            r_coin_inhibit <= 1'b0;
            r_motor_on     <= 1'b0;
            r_hopper_req   <= 1'b0;
            r_done         <= 1'b0;
            r_fault        <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A vend arriving mid-sequence is only flagged; clear wins.
            if (clear_fault) begin
                r_overrun <= 1'b0;
            end else if (vend && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (vend) begin
                        r_remaining    <= change;
                        r_coin_inhibit <= 1'b1;
                        if (change_valid(change)) begin
                            r_state    <= ST_MOTOR;
                            r_motor_on <= 1'b1;
                        end else begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                end

                ST_MOTOR: begin
                    if (w_motor_zero) begin
                        r_motor_on <= 1'b0;
                        if (r_remaining != '0) begin
                            r_state      <= ST_PAY_REQ;
                            r_hopper_req <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_PAY_REQ: begin
                    if (hopper_ack) begin
                        r_state      <= ST_PAY_REL;
                        r_hopper_req <= 1'b0;
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - c_one_coin;
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_FAULT;
                        r_hopper_req <= 1'b0;
                        r_fault      <= 1'b1;
                    end
                end

                ST_PAY_REL: begin
                    if (!hopper_ack) begin
                        if (r_remaining != '0) begin
                            r_state      <= ST_PAY_REQ;
                            r_hopper_req <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state        <= ST_IDLE;
                    r_coin_inhibit <= 1'b0;
                end

                ST_FAULT: begin
                    if (clear_fault) begin
                        r_state        <= ST_IDLE;
                        r_remaining    <= '0;
                        r_coin_inhibit <= 1'b0;
                        r_fault        <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= ST_IDLE;
                    r_remaining    <= '0;
                    r_coin_inhibit <= 1'b0;
                    r_motor_on     <= 1'b0;
                    r_hopper_req   <= 1'b0;
                    r_fault        <= 1'b0;
                end
            endcase
        end
    end

    assign coin_inhibit = r_coin_inhibit;
    assign motor_on     = r_motor_on;
    assign hopper_req   = r_hopper_req;
    assign done         = r_done;
    assign fault        = r_fault;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_dispense_sequencer
//  Description : Self-checking bench. Each transaction is planned up front as
//                a cycle timeline (motor window, per-coin handshake windows,
//                done cycle, fault window, overrun window) and the DUT
//                outputs are compared against it every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vend_dispense_sequencer;

    localparam int c_motor = 8;
    localparam int c_ackto = 16;
    localparam int c_maxc  = 160;

    logic       clock = 1'b0;
    logic       reset;
    logic       vend;
    logic [2:0] change;
    logic       hopper_ack;
    logic       clear_fault;
    logic       coin_inhibit;
    logic       motor_on;
    logic       hopper_req;
    logic       done;
    logic       fault;
    logic       overrun;

    always #5 clock = ~clock;

    vend_dispense_sequencer #(
        .MOTOR_CYCLES (c_motor),
        .ACK_TIMEOUT  (c_ackto)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .vend         (vend),
        .change       (change),
        .hopper_ack   (hopper_ack),
        .clear_fault  (clear_fault),
        .coin_inhibit (coin_inhibit),
        .motor_on     (motor_on),
        .hopper_req   (hopper_req),
        .done         (done),
        .fault        (fault),
        .overrun      (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;
    int txn_id   = 0;

    // Expected output vector {coin_inhibit, motor_on, hopper_req, done, fault, overrun}
    logic [5:0] exp_o [0:c_maxc];
    bit         d_vend [0:c_maxc];
    bit         d_ack  [0:c_maxc];
    bit         d_clr  [0:c_maxc];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {coin_inhibit, motor_on, hopper_req, done, fault, overrun};
    endfunction

    // Plan and run one vend. abort_second: pull reset while the second coin
    // request is up, then return.
    task automatic run_txn(input int chg, input bit use_ovr, input bit abort_second);
        int s, a, b, q, d, v, c, cf, last, abort_at;
        for (int k = 0; k <= c_maxc; k++) begin
            exp_o[k]  = '0;
            d_vend[k] = 1'b0;
            d_ack[k]  = 1'b0;
            d_clr[k]  = 1'b0;
        end
        v        = -1;
        abort_at = -1;
        d_vend[0] = 1'b1;
        txn_id++;

        if (chg <= 5) begin
            for (int k = 1; k <= c_motor; k++) exp_o[k][4] = 1'b1;
            s = c_motor + 1;
            for (int i = 0; i < chg; i++) begin
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 2);
                if (i == 1 && abort_second) abort_at = s;
                for (int k = s; k <= s + a; k++) exp_o[k][3] = 1'b1;
                for (int k = s + a; k <= s + a + b; k++) d_ack[k] = 1'b1;
                q = s + a + b + 1;
                s = q + 1;
            end
            d = s;
            exp_o[d][2] = 1'b1;
            for (int k = 1; k <= d; k++) exp_o[k][5] = 1'b1;
            c = d + 1;
            d_clr[c] = 1'b1;
            if (use_ovr) v = $urandom_range(2, c_motor - 1);
            last = c + 2;
        end else begin
            cf = 1 + $urandom_range(1, 4);
            d_clr[cf] = 1'b1;
            for (int k = 1; k <= cf; k++) begin
                exp_o[k][5] = 1'b1;
                exp_o[k][1] = 1'b1;
            end
            c = cf;
            if (use_ovr) v = $urandom_range(1, cf);
            last = cf + 2;
        end

        if (v > 0) begin
            d_vend[v] = 1'b1;
            for (int k = v + 1; k <= c; k++) exp_o[k][0] = 1'b1;
        end

        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            check_val($sformatf("t%0d chg%0d cyc%0d", txn_id, chg, k), 32'(outs()), 32'(exp_o[k]));
            if (k == abort_at) begin
                reset       = 1'b0;
                vend        = 1'b0;
                hopper_ack  = 1'b0;
                clear_fault = 1'b0;
                #1;
                check_val($sformatf("t%0d async reset", txn_id), 32'(outs()), 32'd0);
                @(negedge clock);
                reset = 1'b1;
                return;
            end
            vend        = d_vend[k];
            change      = (k == 0) ? 3'(chg) : 3'($urandom_range(0, 7));
            hopper_ack  = d_ack[k];
            clear_fault = d_clr[k];
        end
        vend        = 1'b0;
        hopper_ack  = 1'b0;
        clear_fault = 1'b0;
    endtask

    // Hopper never acknowledges: with the watchdog the request times out,
    // otherwise it waits indefinitely and reset is the only way out.
    task automatic run_stuck_hopper();
        @(negedge clock);
        vend   = 1'b1;
        change = 3'd2;
        for (int k = 1; k <= c_motor + 101; k++) begin
            @(negedge clock);
            vend = 1'b0;
            if (k == c_motor + 1)
                check_val("stuck req rise", 32'({hopper_req, motor_on, fault}), 32'b100);
`ifdef DISPENSE_TIMEOUT_EN
            if (k == c_motor + c_ackto)
                check_val("wd last wait", 32'({hopper_req, fault}), 32'b10);
            if (k == c_motor + c_ackto + 1) begin
                check_val("wd fault", 32'(outs()), 32'b100010);
                clear_fault = 1'b1;
                @(negedge clock);
                clear_fault = 1'b0;
                check_val("wd cleared", 32'(outs()), 32'd0);
                return;
            end
`else
            if (k == c_motor + 101)
                check_val("no wd still req", 32'(outs()), 32'b101000);
`endif
        end
        reset = 1'b0;
        #1;
        check_val("stuck reset", 32'(outs()), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        vend        = 1'b0;
        change      = 3'd0;
        hopper_ack  = 1'b0;
        clear_fault = 1'b0;
        repeat (3) @(negedge clock);
        check_val("reset outputs", 32'(outs()), 32'd0);
        reset = 1'b1;

        run_txn(0, 1'b0, 1'b0);
        run_txn(3, 1'b0, 1'b0);
        run_txn(6, 1'b0, 1'b0);
        run_txn(2, 1'b1, 1'b0);
        run_txn(7, 1'b1, 1'b0);
        run_txn(5, 1'b0, 1'b0);
        run_stuck_hopper();
        run_txn(3, 1'b0, 1'b1);
        run_txn(4, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            run_txn(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
